// File: rtl/sv_pkg.sv
// sv_pkg: shared FSM states and default widths for the sample volume accumulator.
package sv_pkg;
   localparam int DEF_IN_W = 32;
   localparam int DEF_LEN_W = 8;
   localparam int DEF_GATE_W = 6;
   localparam int DEF_OUT_W = 32;
   typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;
endpackage

// File: rtl/sample_volume_accumulator_if.sv
// sample_volume_accumulator_if: sample input stream and sample volume output stream.
interface sample_volume_accumulator_if import sv_pkg::*; #(
   parameter int IN_W = DEF_IN_W,
   parameter int GATE_W = DEF_GATE_W,
   parameter int OUT_W = DEF_OUT_W
);
   logic in_valid;
   logic signed [IN_W-1:0] in_re, in_im;
   logic signed [OUT_W-1:0] sv_re, sv_im;
   logic sv_valid, line_done;
   logic [GATE_W-1:0] sv_gate;
   modport master (output in_valid, in_re, in_im, input sv_re, sv_im, sv_valid, sv_gate, line_done);
   modport slave (input in_valid, in_re, in_im, output sv_re, sv_im, sv_valid, sv_gate, line_done);
endinterface

// File: rtl/sv_out_narrow.sv
// sv_out_narrow: ACC_W -> OUT_W narrowing; clamps when SV_SATURATE_EN is defined, else wraps.
module sv_out_narrow #(
   parameter int ACC_W = 40,
   parameter int OUT_W = 32
) (
   input logic signed [ACC_W-1:0] acc_i,
   output logic signed [OUT_W-1:0] out_o,
   output logic sat_o
);
`ifdef SV_SATURATE_EN
   logic [ACC_W-OUT_W:0] hi;
   assign hi = acc_i[ACC_W-1:OUT_W-1];
   assign sat_o = !(&hi || ~|hi);
   always_comb out_o = !sat_o ? acc_i[OUT_W-1:0] : acc_i[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
`else
   logic unused_hi;
   assign unused_hi = ^acc_i[ACC_W-1:OUT_W];
   assign out_o = acc_i[OUT_W-1:0];
   assign sat_o = 1'b0;
`endif
endmodule

// File: rtl/sample_volume_accumulator.sv
// sample_volume_accumulator: per-gate I/Q window integrator for one PRF line.
// Optional output clamping with sticky sat_flag via SV_SATURATE_EN.
module sample_volume_accumulator import sv_pkg::*; #(
   parameter int IN_W = DEF_IN_W,
   parameter int LEN_W = DEF_LEN_W,
   parameter int GATE_W = DEF_GATE_W,
   parameter int OUT_W = DEF_OUT_W
) (
   input logic clk,
   input logic reset,
   input logic line_start,
   input logic [LEN_W-1:0] sv_len,
   input logic [GATE_W-1:0] num_gates,
   sample_volume_accumulator_if.slave s,
   output logic busy,
   output logic sat_flag
);
   localparam int ACC_W = IN_W + LEN_W;
   state_t state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d, cc, cur_len;
   logic [GATE_W-1:0] ng_q, ng_d, gate_q, gate_d, cg, cur_ng, sv_gate_q, sv_gate_d;
   logic signed [ACC_W-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d, samp_re, samp_im, sum_re, sum_im;
   logic signed [OUT_W-1:0] sv_re_q, sv_re_d, sv_im_q, sv_im_d, nar_re, nar_im;
   logic sv_valid_q, sv_valid_d, done_q, done_d, sat_q, sat_d, sat_re, sat_im;
   logic start, old_fin, abort, take, fin, lastg;
   assign start = line_start && num_gates != '0;
   assign old_fin = s.in_valid && cnt_q == len_q;
   // Abort only when line_start does not coincide with the old window's final sample.
   assign abort = state_q == ACCUM && line_start && !old_fin;
   assign cur_len = abort ? sv_len : len_q;
   assign cur_ng = abort ? num_gates : ng_q;
   assign cc = abort ? '0 : cnt_q;
   assign cg = abort ? '0 : gate_q;
   assign take = state_q == ACCUM && s.in_valid && !(abort && !start);
   assign fin = take && cc == cur_len;
   assign lastg = cg == GATE_W'(cur_ng - 1'b1);
   assign samp_re = {{LEN_W{s.in_re[IN_W-1]}}, s.in_re};
   assign samp_im = {{LEN_W{s.in_im[IN_W-1]}}, s.in_im};
   assign sum_re = cc == '0 ? samp_re : acc_re_q + samp_re;
   assign sum_im = cc == '0 ? samp_im : acc_im_q + samp_im;
   sv_out_narrow #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_nar_re (.acc_i(sum_re), .out_o(nar_re), .sat_o(sat_re));
   sv_out_narrow #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_nar_im (.acc_i(sum_im), .out_o(nar_im), .sat_o(sat_im));
   always_comb begin
      state_d = state_q;
      len_d = len_q;
      ng_d = ng_q;
      gate_d = gate_q;
      cnt_d = cnt_q;
      acc_re_d = acc_re_q;
      acc_im_d = acc_im_q;
      sv_re_d = sv_re_q;
      sv_im_d = sv_im_q;
      sv_gate_d = sv_gate_q;
      sv_valid_d = 1'b0;
      done_d = 1'b0;
      sat_d = sat_q;
      if (state_q == ACCUM) begin
         len_d = cur_len;
         ng_d = cur_ng;
         gate_d = cg;
         cnt_d = cc;
         if (abort && start) sat_d = 1'b0;
         if (take) begin
            acc_re_d = sum_re;
            acc_im_d = sum_im;
            cnt_d = fin ? '0 : cc + 1'b1;
         end
         if (fin) begin
            sv_valid_d = 1'b1;
            sv_gate_d = cg;
            sv_re_d = nar_re;
            sv_im_d = nar_im;
            sat_d = sat_d | sat_re | sat_im;
            done_d = lastg;
            gate_d = lastg ? '0 : cg + 1'b1;
            state_d = lastg ? IDLE : ACCUM;
         end
         if (line_start && !start) state_d = IDLE;
      end
      // A window finishing under line_start is emitted first; the new line begins next cycle.
      if (start && (state_q == IDLE || (fin && !abort))) begin
         state_d = ACCUM;
         len_d = sv_len;
         ng_d = num_gates;
         gate_d = '0;
         cnt_d = '0;
         sat_d = 1'b0;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         len_q <= '0;
         ng_q <= '0;
         gate_q <= '0;
         cnt_q <= '0;
         acc_re_q <= '0;
         acc_im_q <= '0;
         sv_re_q <= '0;
         sv_im_q <= '0;
         sv_gate_q <= '0;
         sv_valid_q <= 1'b0;
         done_q <= 1'b0;
         sat_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q <= len_d;
         ng_q <= ng_d;
         gate_q <= gate_d;
         cnt_q <= cnt_d;
         acc_re_q <= acc_re_d;
         acc_im_q <= acc_im_d;
         sv_re_q <= sv_re_d;
         sv_im_q <= sv_im_d;
         sv_gate_q <= sv_gate_d;
         sv_valid_q <= sv_valid_d;
         done_q <= done_d;
         sat_q <= sat_d;
      end
   end
   assign s.sv_re = sv_re_q;
   assign s.sv_im = sv_im_q;
   assign s.sv_gate = sv_gate_q;
   assign s.sv_valid = sv_valid_q;
   assign s.line_done = done_q;
   assign busy = state_q == ACCUM;
   assign sat_flag = sat_q;
endmodule

// File: tb/tb_sample_volume_accumulator.sv
// tb_sample_volume_accumulator: directed checks on a 32-bit and a 16-bit output instance.
module tb_sample_volume_accumulator;
   logic clk = 1'b0, reset = 1'b1, line_start = 1'b0, in_valid = 1'b0;
   logic [31:0] in_re = '0, in_im = '0;
   logic [7:0] sv_len = '0;
   logic [5:0] num_gates = '0;
   logic busy_a, sat_a, busy_b, sat_b;
   int n_vec = 0, n_err = 0;
`ifdef SV_SATURATE_EN
   localparam int EXP_POS = 32767, EXP_NEG = -32768;
   localparam logic EXP_SAT = 1'b1;
`else
   localparam int EXP_POS = -5536, EXP_NEG = 5536;
   localparam logic EXP_SAT = 1'b0;
`endif
   sample_volume_accumulator_if if_a ();
   sample_volume_accumulator_if #(.OUT_W(16)) if_b ();
   assign if_a.in_valid = in_valid;
   assign if_a.in_re = in_re;
   assign if_a.in_im = in_im;
   assign if_b.in_valid = in_valid;
   assign if_b.in_re = in_re;
   assign if_b.in_im = in_im;
   sample_volume_accumulator u_a (.clk(clk), .reset(reset), .line_start(line_start), .sv_len(sv_len),
      .num_gates(num_gates), .s(if_a), .busy(busy_a), .sat_flag(sat_a));
   sample_volume_accumulator #(.OUT_W(16)) u_b (.clk(clk), .reset(reset), .line_start(line_start),
      .sv_len(sv_len), .num_gates(num_gates), .s(if_b), .busy(busy_b), .sat_flag(sat_b));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_vec++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(want));
      end
   endtask
   task automatic cyc(input logic ls, input logic v, input int re, input int im);
      line_start = ls;
      in_valid = v;
      in_re = re;
      in_im = im;
      @(posedge clk);
      #1;
      line_start = 1'b0;
      in_valid = 1'b0;
   endtask
   initial begin
      logic seen;
      #2;
      chk("rst_valid", if_a.sv_valid, 0);
      chk("rst_re", if_a.sv_re, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", if_a.line_done, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      // two gates of four samples
      sv_len = 3; num_gates = 2;
      cyc(1, 0, 0, 0);
      chk("t1_busy", busy_a, 1);
      cyc(0, 1, 1, -1); cyc(0, 1, 2, -1); cyc(0, 1, 3, -1);
      chk("t1_novalid", if_a.sv_valid, 0);
      cyc(0, 1, 4, -1);
      chk("t1_g0_valid", if_a.sv_valid, 1);
      chk("t1_g0_re", if_a.sv_re, 10);
      chk("t1_g0_im", if_a.sv_im, -4);
      chk("t1_g0_gate", if_a.sv_gate, 0);
      chk("t1_g0_done", if_a.line_done, 0);
      cyc(0, 1, 5, -1);
      chk("t1_strobe_1cyc", if_a.sv_valid, 0);
      chk("t1_hold_re", if_a.sv_re, 10);
      cyc(0, 1, 6, -1); cyc(0, 1, 7, -1); cyc(0, 1, 8, -1);
      chk("t1_g1_valid", if_a.sv_valid, 1);
      chk("t1_g1_re", if_a.sv_re, 26);
      chk("t1_g1_im", if_a.sv_im, -4);
      chk("t1_g1_gate", if_a.sv_gate, 1);
      chk("t1_g1_done", if_a.line_done, 1);
      chk("t1_idle", busy_a, 0);
      // gapped input
      sv_len = 1; num_gates = 1;
      cyc(1, 0, 0, 0);
      cyc(0, 1, 5, 0);
      cyc(0, 0, 99, 0);
      chk("t2_gap_novalid", if_a.sv_valid, 0);
      cyc(0, 1, 7, 0);
      chk("t2_valid", if_a.sv_valid, 1);
      chk("t2_re", if_a.sv_re, 12);
      chk("t2_done", if_a.line_done, 1);
      // line_start coinciding with a final sample
      sv_len = 1; num_gates = 2;
      cyc(1, 0, 0, 0);
      cyc(0, 1, 1, 0);
      sv_len = 0; num_gates = 1;
      cyc(1, 1, 2, 0);
      chk("tc_valid", if_a.sv_valid, 1);
      chk("tc_re", if_a.sv_re, 3);
      chk("tc_done", if_a.line_done, 0);
      chk("tc_busy", busy_a, 1);
      cyc(0, 1, 9, 0);
      chk("tc_new_re", if_a.sv_re, 9);
      chk("tc_new_done", if_a.line_done, 1);
      // abort mid-window of gate 1
      sv_len = 3; num_gates = 2;
      cyc(1, 0, 0, 0);
      cyc(0, 1, 1, 0); cyc(0, 1, 1, 0); cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);
      chk("t3_g0_re", if_a.sv_re, 4);
      cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);
      sv_len = 1; num_gates = 1;
      cyc(1, 1, 100, 0);
      chk("t3_abort_novalid", if_a.sv_valid, 0);
      sv_len = 7; num_gates = 9;
      cyc(0, 1, 50, 0);
      chk("t3_valid", if_a.sv_valid, 1);
      chk("t3_re", if_a.sv_re, 150);
      chk("t3_gate", if_a.sv_gate, 0);
      chk("t3_done", if_a.line_done, 1);
      // zero gates
      sv_len = 0; num_gates = 0;
      cyc(1, 0, 0, 0);
      chk("t4_busy", busy_a, 0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1, i + 1, 0);
         seen = seen | if_a.sv_valid | busy_a;
      end
      chk("t4_quiet", seen, 0);
      // narrowing to 16 bits
      sv_len = 1; num_gates = 1;
      cyc(1, 0, 0, 0);
      cyc(0, 1, 30000, 0); cyc(0, 1, 30000, 0);
      chk("t5_a_re", if_a.sv_re, 60000);
      chk("t5_a_sat", sat_a, 0);
      chk("t5_b_re", if_b.sv_re, EXP_POS);
      chk("t5_b_sat", sat_b, EXP_SAT);
      cyc(1, 0, 0, 0);
      chk("t5_sat_clr", sat_b, 0);
      cyc(0, 1, -30000, 0); cyc(0, 1, -30000, 0);
      chk("t5_a_neg", if_a.sv_re, -60000);
      chk("t5_b_neg", if_b.sv_re, EXP_NEG);
      chk("t5_b_negsat", sat_b, EXP_SAT);
      // asynchronous reset mid-window
      sv_len = 2; num_gates = 1;
      cyc(1, 0, 0, 0);
      cyc(0, 1, 5, 5); cyc(0, 1, 5, 5);
      reset = 1'b1;
      #2;
      chk("t6_busy", busy_a, 0);
      chk("t6_re", if_a.sv_re, 0);
      chk("t6_b_re", if_b.sv_re, 0);
      chk("t6_sat", sat_b, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      cyc(1, 0, 0, 0);
      cyc(0, 1, 2, 1); cyc(0, 1, 3, 1); cyc(0, 1, 4, 1);
      chk("t6_valid", if_a.sv_valid, 1);
      chk("t6_new_re", if_a.sv_re, 9);
      chk("t6_new_im", if_a.sv_im, 3);
      chk("t6_done", if_a.line_done, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
